register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//   MIPS 32x32-bit general-purpose register file for the single-cycle datapath.
//   It receives the write-back address chosen by the RegDst write-register mux, plus WriteData and RegWrite.
//   It returns ReadData1 to the ALU and ReadData2 to the ALUsrc operand mux and data memory.
//   Register $zero is hardwired to 0. An optional write-through bypass supports later pipelining.
// PARAMETERS
//   BYPASS   1             1: read of the register being written this cycle returns WriteData; 0: returns the stored value
//   SP_INIT  32'h0000_3FFC reset value of $sp (r29)
//   GP_INIT  32'h0000_1800 reset value of $gp (r28)
// PORTS
//   clk            in   1   single clock, rising-edge active
//   rst_n          in   1   asynchronous, active-low reset
//   ReadRegister1  in   5   rs address
//   ReadRegister2  in   5   rt address
//   WriteRegister  in   5   destination address (from the RegDst mux)
//   WriteData      in   32  write-back value
//   RegWrite       in   1   write enable (from Control)
//   ReadData1      out  32  contents of ReadRegister1
//   ReadData2      out  32  contents of ReadRegister2
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - Reset (rst_n=0, no clock required):
//     - r28 <= GP_INIT, r29 <= SP_INIT, every other register <= 0.
//     - Reset takes effect immediately and overrides any write in the same cycle.
//     - While rst_n=0, reads return the reset values: 0, GP_INIT or SP_INIT.
//   - Write:
//     - On posedge clk with rst_n=1 and RegWrite=1, reg[WriteRegister] <= WriteData.
//     - RegWrite=0: no register changes.
//     - WriteRegister=0: write is discarded; r0 stays 0.
//   - Read: combinational, zero-cycle latency.
//     - ReadDataN = 0 when ReadRegisterN=0.
//     - Otherwise, with BYPASS=1 and RegWrite=1 and ReadRegisterN==WriteRegister (nonzero), ReadDataN = WriteData.
//     - Otherwise ReadDataN = reg[ReadRegisterN].
//   - Both read ports are independent. Both may address the same register, and both may match WriteRegister at once.
//   - With BYPASS=0, a read of the register being written returns the old value until the next edge.
//   - Reset asserted mid-cycle after a write edge: the written value is lost and the reset value wins.
//   - Release of rst_n between edges: the first write is taken at the next rising edge.
//   - No X propagation: every register has a defined reset value, and the address width covers all 32 entries.
// TESTING
//   1. Reset: pulse rst_n low, sweep all 32 read addresses.
//      -> r28=32'h0000_1800, r29=32'h0000_3FFC, all others 0.
//   2. Write/read: RegWrite=1, WriteRegister=8, WriteData=32'hDEAD_BEEF, clock; then ReadRegister1=8, ReadRegister2=8.
//      -> both ports read 32'hDEAD_BEEF.
//   3. $zero: write 32'hFFFF_FFFF to r0, clock.
//      -> ReadData1 with ReadRegister1=0 is 32'h0000_0000.
//   4. Write inhibit: RegWrite=0, WriteRegister=9, WriteData=32'h1234_5678, clock.
//      -> r9 still 0.
//   5. Bypass: BYPASS=1, r10=5, same cycle RegWrite=1, WriteRegister=10, WriteData=7, ReadRegister2=10.
//      -> ReadData2=7 before the edge.
//      With BYPASS=0 -> ReadData2=5 before the edge, 7 after.
//   6. Async reset mid-cycle: write r29=32'h1 at an edge, drop rst_n between edges.
//      -> r29 reads 32'h0000_3FFC with no clock edge.

Source files
------------

// File: rtl/register_bank.sv
// 32x32-bit MIPS general-purpose register file.
// Two combinational read ports, one synchronous write port, $zero hardwired to 0,
// and an optional write-through bypass from the write port to both read ports.
module register_bank #(
  parameter bit          BYPASS  = 1'b1,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] GP_ADDR = ADDR_W'(28);
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(29);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  // Reset value of each entry: $gp and $sp are preloaded, everything else clears.
  function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr == GP_ADDR) val = GP_INIT;
    if (addr == SP_ADDR) val = SP_INIT;
    return val;
  endfunction

  // Writes to $zero are dropped so r0 keeps its reset value of 0.
  assign wr_en = RegWrite && (WriteRegister != '0);

  // Register array: asynchronous reset to defined values, write on rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= init_value(ADDR_W'(i));
      end
    end else if (wr_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Read port 1: $zero forced to 0, bypass only while out of reset.
  always_comb begin
    ReadData1 = '0;
    if (ReadRegister1 != '0) begin
      if (BYPASS && rst_n && wr_en && (ReadRegister1 == WriteRegister)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = regs[ReadRegister1];
      end
    end
  end

  // Read port 2: independent copy of port 1 logic.
  always_comb begin
    ReadData2 = '0;
    if (ReadRegister2 != '0) begin
      if (BYPASS && rst_n && wr_en && (ReadRegister2 == WriteRegister)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = regs[ReadRegister2];
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank: one bypassed and one non-bypassed
// instance share the same stimulus and are checked against hand-computed values.
module tb_register_bank;

  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
  localparam logic [31:0] GP_INIT = 32'h0000_1800;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int passed;
  int total;

  register_bank #(.BYPASS(1'b1), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .WriteRegister(wr), .WriteData(wd), .RegWrite(we),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  register_bank #(.BYPASS(1'b0), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut_nob (
    .clk(clk), .rst_n(rst_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .WriteRegister(wr), .WriteData(wd), .RegWrite(we),
    .ReadData1(rd1_n), .ReadData2(rd2_n)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] reset_val(input int idx);
    if (idx == 28) return GP_INIT;
    if (idx == 29) return SP_INIT;
    return 32'h0;
  endfunction

  task automatic test_reset();
    logic [31:0] exp1, exp2;
    // Attempt a write while reset is held; reset must win.
    @(negedge clk);
    we = 1'b1; wr = 5'd28; wd = 32'hAAAA_5555;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      #1;
      exp1 = reset_val(i);
      exp2 = reset_val(31 - i);
      total++; if (rd1_b !== exp1) $display("FAIL reset_byp_p1 r%0d got %h exp %h", i, rd1_b, exp1); else passed++;
      total++; if (rd2_b !== exp2) $display("FAIL reset_byp_p2 r%0d got %h exp %h", 31 - i, rd2_b, exp2); else passed++;
      total++; if (rd1_n !== exp1) $display("FAIL reset_nob_p1 r%0d got %h exp %h", i, rd1_n, exp1); else passed++;
      total++; if (rd2_n !== exp2) $display("FAIL reset_nob_p2 r%0d got %h exp %h", 31 - i, rd2_n, exp2); else passed++;
    end
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; wr = 5'd8; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    we = 1'b0; rr1 = 5'd8; rr2 = 5'd8;
    #1;
    total++; if (rd1_b !== 32'hDEAD_BEEF) $display("FAIL write_read_byp_p1 got %h exp DEADBEEF", rd1_b); else passed++;
    total++; if (rd2_b !== 32'hDEAD_BEEF) $display("FAIL write_read_byp_p2 got %h exp DEADBEEF", rd2_b); else passed++;
    total++; if (rd1_n !== 32'hDEAD_BEEF) $display("FAIL write_read_nob_p1 got %h exp DEADBEEF", rd1_n); else passed++;
    total++; if (rd2_n !== 32'hDEAD_BEEF) $display("FAIL write_read_nob_p2 got %h exp DEADBEEF", rd2_n); else passed++;
  endtask

  task automatic test_zero();
    @(negedge clk);
    we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; rr1 = 5'd0; rr2 = 5'd0;
    #1;
    // Bypass must not expose WriteData for $zero.
    total++; if (rd1_b !== 32'h0) $display("FAIL zero_bypass got %h exp 00000000", rd1_b); else passed++;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    total++; if (rd1_b !== 32'h0) $display("FAIL zero_byp got %h exp 00000000", rd1_b); else passed++;
    total++; if (rd1_n !== 32'h0) $display("FAIL zero_nob got %h exp 00000000", rd1_n); else passed++;
  endtask

  task automatic test_inhibit();
    @(negedge clk);
    we = 1'b0; wr = 5'd9; wd = 32'h1234_5678; rr1 = 5'd9; rr2 = 5'd8;
    @(posedge clk); #1;
    total++; if (rd1_b !== 32'h0) $display("FAIL inhibit_byp got %h exp 00000000", rd1_b); else passed++;
    total++; if (rd1_n !== 32'h0) $display("FAIL inhibit_nob got %h exp 00000000", rd1_n); else passed++;
    total++; if (rd2_n !== 32'hDEAD_BEEF) $display("FAIL inhibit_r8 got %h exp DEADBEEF", rd2_n); else passed++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; wr = 5'd10; wd = 32'd5;
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    we = 1'b1; wr = 5'd10; wd = 32'd7; rr1 = 5'd10; rr2 = 5'd10;
    #1;
    total++; if (rd2_b !== 32'd7) $display("FAIL bypass_byp_p2_pre got %h exp 00000007", rd2_b); else passed++;
    total++; if (rd1_b !== 32'd7) $display("FAIL bypass_byp_p1_pre got %h exp 00000007", rd1_b); else passed++;
    total++; if (rd2_n !== 32'd5) $display("FAIL bypass_nob_p2_pre got %h exp 00000005", rd2_n); else passed++;
    total++; if (rd1_n !== 32'd5) $display("FAIL bypass_nob_p1_pre got %h exp 00000005", rd1_n); else passed++;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    total++; if (rd2_b !== 32'd7) $display("FAIL bypass_byp_post got %h exp 00000007", rd2_b); else passed++;
    total++; if (rd2_n !== 32'd7) $display("FAIL bypass_nob_post got %h exp 00000007", rd2_n); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      we = 1'b1; wr = 5'(i); wd = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(5 - i);
      #1;
      exp = 32'h1000_0000 + 32'(i);
      total++; if (rd1_n !== exp) $display("FAIL b2b_p1 r%0d got %h exp %h", i, rd1_n, exp); else passed++;
      exp = 32'h1000_0000 + 32'(5 - i);
      total++; if (rd2_b !== exp) $display("FAIL b2b_p2 r%0d got %h exp %h", 5 - i, rd2_b, exp); else passed++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    we = 1'b1; wr = 5'd29; wd = 32'h1; rr1 = 5'd29; rr2 = 5'd8;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    total++; if (rd1_n !== 32'h1) $display("FAIL async_pre r29 got %h exp 00000001", rd1_n); else passed++;
    // Drop reset between edges with a write pending on r29.
    we = 1'b1; wr = 5'd29; wd = 32'h2;
    #1 rst_n = 1'b0;
    #1;
    total++; if (rd1_n !== SP_INIT) $display("FAIL async_r29_nob got %h exp %h", rd1_n, SP_INIT); else passed++;
    total++; if (rd1_b !== SP_INIT) $display("FAIL async_r29_byp got %h exp %h", rd1_b, SP_INIT); else passed++;
    total++; if (rd2_b !== 32'h0) $display("FAIL async_r8 got %h exp 00000000", rd2_b); else passed++;
    // Release between edges; the next rising edge takes the write.
    @(negedge clk); #2;
    rst_n = 1'b1;
    we = 1'b1; wr = 5'd5; wd = 32'h0000_00AA; rr1 = 5'd5; rr2 = 5'd28;
    #1;
    total++; if (rd1_n !== 32'h0) $display("FAIL release_pre got %h exp 00000000", rd1_n); else passed++;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    total++; if (rd1_n !== 32'h0000_00AA) $display("FAIL release_post got %h exp 000000AA", rd1_n); else passed++;
    total++; if (rd2_n !== GP_INIT) $display("FAIL release_gp got %h exp %h", rd2_n, GP_INIT); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    rr1 = '0; rr2 = '0; wr = '0; wd = '0; we = 1'b0;
    test_reset();
    test_write_read();
    test_zero();
    test_inhibit();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
